shot_trigger_gen: RTL
=====================

// Module: shot_trigger_gen
// PURPOSE
//  Producer side of the shot interface: turns the raw light-gun trigger into clean
//  single-cycle 'shot' pulses for the shot counter. Synchronises and debounces the
//  trigger, gates firing on game state and remaining ammo, and runs a req/ack
//  screen-flash handshake with the video block for hit detection.
// PARAMETERS
//  DEBOUNCE_CYCLES  500_000    stable cycles needed to accept a level change (10 ms @ 50 MHz)
//  COOLDOWN_CYCLES  2_500_000  minimum dead time after flash_ack before the next shot (50 ms)
//  PLAY_STATE       3'd2       game-FSM encoding in which firing is allowed
// PORTS
//  Clk            in   1  system clock
//  Reset          in   1  asynchronous, active-low reset
//  trigger_n      in   1  raw trigger, active-low, asynchronous to Clk
//  state          in   3  game FSM state
//  no_shots_left  in   1  from shot counter; 1 = magazine empty
//  flash_ack      in   1  video block: flash frame has been drawn
//  shot           out  1  one-cycle pulse, one per accepted trigger press
//  dry_fire       out  1  one-cycle pulse: press accepted in PLAY_STATE while empty
//  flash_req      out  1  request for a flash frame, held until flash_ack
//  busy           out  1  high in any FSM state other than IDLE
// BEHAVIOUR
//  - Reset low: all outputs 0, FSM = IDLE, counters 0, debounced level = released.
//  - trigger_n passes through a 2-FF synchroniser (reset to 1) and is then inverted.
//  - Debounce: the counter increments while the synced level differs from the
//    debounced level and clears when they match; debounced level toggles when the
//    count reaches DEBOUNCE_CYCLES-1. press_evt is a 1-cycle pulse on a debounced 0->1.
//  - Counter width: $clog2(max(DEBOUNCE_CYCLES,COOLDOWN_CYCLES)+1). Neither counter wraps.
//  - FSM (registered outputs):
//    IDLE:    press_evt & state==PLAY_STATE & !no_shots_left -> FIRE.
//             press_evt & state==PLAY_STATE & no_shots_left  -> dry_fire=1 for 1 cycle,
//             then -> RELEASE.
//             press_evt in any other game state is ignored; stay in IDLE.
//    FIRE:    shot=1 for exactly this cycle -> FLASH.
//    FLASH:   flash_req=1; on flash_ack=1 -> COOLDOWN and load cooldown counter.
//             flash_req deasserts in the cycle after ack is sampled. Never abandoned
//             once raised, even if state leaves PLAY_STATE.
//    COOLDOWN: decrement each cycle; at 0 -> RELEASE. Presses are ignored.
//    RELEASE: wait until the debounced level = released -> IDLE. A held trigger never
//             auto-fires.
//  - Latency: the debounced press is seen at cycle N; shot goes high at N+2
//    (IDLE->FIRE, then the registered output).
//  - Leaving PLAY_STATE during COOLDOWN or RELEASE: the sequence continues unchanged.
//    Only IDLE checks state.
//  - flash_ack while not in FLASH: ignored.
//  - Reset mid-operation: immediate return to reset values. A pending flash_req
//    drops, and the video block must tolerate this.
// STRUCTURE
//  - duck_hunt_pkg: game-state localparams (PLAY_STATE source of truth) and the
//    typedef enum logic [2:0] {IDLE,FIRE,FLASH,COOLDOWN,RELEASE} trig_state_t.
//  - Sub-module trigger_debounce (synchroniser + debounce counter + press_evt),
//    parameterised by DEBOUNCE_CYCLES. FSM and cooldown counter live in the top level.
// TESTING  (run with DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8)
//  1 state=2, ammo ok, trigger_n low for 20 cycles, ack 3 cycles after flash_req
//    -> exactly one shot pulse, flash_req high until ack, busy low again after release.
//  2 trigger bounces low/high every 2 cycles for 30 cycles, then settles high
//    -> no shot, no flash_req.
//  3 state=2, no_shots_left=1, clean press -> dry_fire pulses once, shot stays 0,
//    flash_req stays 0.
//  4 second press 3 cycles into COOLDOWN and held 20 cycles -> no second shot;
//    after release and a new press, second shot occurs.
//  5 press with state=3'd0 -> nothing. Press in play, then state changes during FLASH
//    -> flash_req holds until ack.
//  6 Reset pulled low while in FLASH -> shot, flash_req and busy go 0 asynchronously;
//    after Reset high, FSM is IDLE.

Source files
------------

// File: rtl/duck_hunt_pkg.sv
// Shared game-state encodings and trigger-FSM types for the light-gun shot path.
// The game-state localparams are the single source of truth for the play encoding.
package duck_hunt_pkg;

  localparam logic [2:0] GS_ATTRACT     = 3'd0;
  localparam logic [2:0] GS_ROUND_START = 3'd1;
  localparam logic [2:0] GS_PLAY        = 3'd2;
  localparam logic [2:0] GS_ROUND_END   = 3'd3;
  localparam logic [2:0] GS_GAME_OVER   = 3'd4;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500_000;
  localparam int unsigned COOLDOWN_CYCLES_DEF = 2_500_000;

  typedef enum logic [2:0] {
    IDLE,
    FIRE,
    FLASH,
    COOLDOWN,
    RELEASE
  } trig_state_t;

  // Shared counter width: large enough to hold the bigger of the two limits.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/trigger_debounce.sv
// Two-flop synchroniser and stable-level debouncer for the active-low trigger.
// level_o is the debounced pressed level; press_evt_o pulses once per accepted press.
module trigger_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic trigger_n_i,
  output logic level_o,
  output logic press_evt_o
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_sync;
  logic             deb_q, deb_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchroniser resets to the released (high) level so reset never looks like a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= trigger_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign level_sync = ~sync2_q;

  always_comb begin
    cnt_d   = '0;
    deb_d   = deb_q;
    press_d = 1'b0;
    if (level_sync != deb_q) begin
      if (cnt_q >= DEB_LAST) begin
        deb_d   = level_sync;
        press_d = level_sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      deb_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      press_q <= press_d;
    end
  end

  assign level_o     = deb_q;
  assign press_evt_o = press_q;

endmodule

// File: rtl/shot_trigger_gen.sv
// Turns debounced trigger presses into single shot pulses and runs the flash req/ack handshake.
//   state    | meaning
//   IDLE     | waiting for a press; the only state that looks at the game state
//   FIRE     | press accepted with ammo; shot pulses in the following cycle
//   FLASH    | flash_req raised until flash_ack; never abandoned
//   COOLDOWN | dead time after ack, presses ignored
//   RELEASE  | wait for the trigger to be let go, so a held trigger never re-fires
module shot_trigger_gen
  import duck_hunt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
  parameter logic [2:0]  PLAY_STATE      = GS_PLAY
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       trigger_n,
  input  logic [2:0] state,
  input  logic       no_shots_left,
  input  logic       flash_ack,
  output logic       shot,
  output logic       dry_fire,
  output logic       flash_req,
  output logic       busy
);

  localparam int unsigned      CNT_W     = cnt_width(DEBOUNCE_CYCLES, COOLDOWN_CYCLES);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES);

  trig_state_t      state_q, state_d;
  logic [CNT_W-1:0] cool_q, cool_d;
  logic             shot_q, shot_d;
  logic             dry_q, dry_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             deb_level;
  logic             press_evt;
  logic             in_play;

  trigger_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk_i       (Clk),
    .rst_ni      (Reset),
    .trigger_n_i (trigger_n),
    .level_o     (deb_level),
    .press_evt_o (press_evt)
  );

  assign in_play = (state == PLAY_STATE);

  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    dry_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press_evt && in_play) begin
          if (no_shots_left) begin
            dry_d   = 1'b1;
            state_d = RELEASE;
          end else begin
            state_d = FIRE;
          end
        end
      end
      FIRE:  state_d = FLASH;
      FLASH: begin
        if (flash_ack) begin
          state_d = COOLDOWN;
          cool_d  = COOL_LOAD;
        end
      end
      COOLDOWN: begin
        if (cool_q == '0) begin
          state_d = RELEASE;
        end else begin
          cool_d = cool_q - 1'b1;
        end
      end
      RELEASE: begin
        if (!deb_level) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered decodes of the current state, so shot trails FIRE by one cycle.
    shot_d = (state_q == FIRE);
    req_d  = (state_q == FLASH) && !flash_ack;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cool_q  <= '0;
      shot_q  <= 1'b0;
      dry_q   <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cool_q  <= cool_d;
      shot_q  <= shot_d;
      dry_q   <= dry_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
    end
  end

  assign shot      = shot_q;
  assign dry_fire  = dry_q;
  assign flash_req = req_q;
  assign busy      = busy_q;

endmodule
